// File: rtl/byte_mem_pkg.sv
// Shared types and default sizing for the byte-addressable burst memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package byte_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int MEM_SIZE_DEF  = 1024;
   localparam int MAX_BYTES_DEF = 256;
   localparam int INIT_LAT_DEF  = 10;

endpackage

// File: rtl/byte_ram.sv
// Single-port byte storage, MEM_SIZE x 8.
// Latency: write lands on the clock edge, read data is combinational from the address.
// Backpressure: none; a write is taken on every cycle that we is high.
module byte_ram #(
   parameter int MEM_SIZE = 1024,
   parameter int AW       = $clog2(MEM_SIZE)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [MEM_SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/byte_burst_mem.sv
// Burst memory front end: one request in flight, bounds-checked, then one byte per cycle.
// Latency: first beat INIT_LAT cycles after accept; rejects answer the next cycle.
// Backpressure: reads stall on rd_ready, writes wait on wr_valid; req_ready only in IDLE.
module byte_burst_mem
   import byte_mem_pkg::*;
#(
   parameter int MEM_SIZE  = MEM_SIZE_DEF,
   parameter int MAX_BYTES = MAX_BYTES_DEF,
   parameter int INIT_LAT  = INIT_LAT_DEF,
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [7:0]        rd_data,
   output logic              rsp_valid,
   output logic              rsp_error,
   output logic              busy
);

   localparam int AW    = $clog2(MEM_SIZE);
   localparam int LAT_W = $clog2(INIT_LAT + 1);

   typedef struct packed {
      logic             write;
      logic [AW-1:0]    addr;
      logic [LEN_W-1:0] len;
   } req_t;

   state_e           state, state_nxt;
   req_t             req_q;
   logic [LEN_W-1:0] idx;
   logic [LAT_W-1:0] lat;
   logic             err_q;
   logic             accept;
   logic             bad;
   logic             beat;
   logic             last;
   logic [7:0]       ram_rdata;

   assign accept = req_valid && req_ready;

   // Sum is one bit wider than the address so a huge start address cannot wrap into range.
   assign bad = (({1'b0, req_addr} + (ADDR_W+1)'(req_len)) > (ADDR_W+1)'(MEM_SIZE))
             || (req_len > LEN_W'(MAX_BYTES));

   assign beat = (state == XFER) && (req_q.write ? wr_valid : rd_ready);
   assign last = beat && (idx == req_q.len - LEN_W'(1));

   always_comb begin
      state_nxt = state;
      req_ready = (state == IDLE);
      wr_ready  = (state == XFER) && req_q.write;
      rd_valid  = (state == XFER) && !req_q.write;
      rd_data   = 8'h00;
      rsp_valid = (state == DONE);
      rsp_error = (state == DONE) && err_q;
      busy      = (state != IDLE);
      if (rd_valid) begin
         rd_data = ram_rdata;
      end
      case (state)
         IDLE: if (accept) state_nxt = bad ? DONE : WAIT;
         WAIT: if (lat == '0) state_nxt = (req_q.len == '0) ? DONE : XFER;
         XFER: if (last) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
         idx   <= '0;
         lat   <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            req_q.write <= req_write;
            req_q.addr  <= AW'(req_addr);
            req_q.len   <= req_len;
            err_q       <= bad;
            idx         <= '0;
            lat         <= LAT_W'(INIT_LAT - 1);
         end
         if ((state == WAIT) && (lat != '0)) begin
            lat <= lat - LAT_W'(1);
         end
         if (beat) begin
            idx <= idx + LEN_W'(1);
         end
      end
   end

   byte_ram #(
      .MEM_SIZE (MEM_SIZE),
      .AW       (AW)
   ) u_ram (
      .clk   (clk),
      .we    (beat && req_q.write),
      .addr  (req_q.addr + AW'(idx)),
      .wdata (wr_data),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_byte_burst_mem.sv
// Scoreboarded bench for byte_burst_mem: read bytes and completion codes are queued at request time.
module tb_byte_burst_mem;

   localparam int INIT_LAT = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [15:0] req_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [7:0]  rd_data;
   logic        rsp_valid;
   logic        rsp_error;
   logic        busy;

   always #5 clk = ~clk;

   byte_burst_mem #(
      .MEM_SIZE  (1024),
      .MAX_BYTES (256),
      .INIT_LAT  (INIT_LAT),
      .ADDR_W    (64),
      .LEN_W     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rsp_valid (rsp_valid),
      .rsp_error (rsp_error),
      .busy      (busy)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] model [0:1023];
   logic [7:0] rd_q [$];
   logic       rsp_q [$];
   logic [7:0] wbuf [0:7];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input logic wr, input logic [63:0] addr, input logic [15:0] len,
                            input bit tog, input bit exp_err);
      int         c, beats, first, done_c, exp_beats, base;
      bit         stall;
      logic [7:0] held;
      logic       exp_rsp;
      exp_beats = exp_err ? 0 : int'(len);
      base      = int'(addr[9:0]);
      if (!wr) begin
         for (int i = 0; i < exp_beats; i++) rd_q.push_back(model[base + i]);
      end
      rsp_q.push_back(exp_err);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_len   = len;
      wr_valid  = 1'b1;
      wr_data   = wr ? wbuf[0] : 8'hEE;
      rd_ready  = 1'b0;
      tick();
      req_valid = 1'b0;
      c = 0; beats = 0; first = -1; done_c = -1; stall = 0; held = 8'h00;
      chk("busy_after_accept", busy, 1);
      while (c < 400) begin
         if (rsp_valid) begin
            done_c = c;
            break;
         end
         chk("rsp_error_quiet", rsp_error, 0);
         if (rd_valid) begin
            if (first < 0) first = c;
            if (stall) chk("rd_hold", rd_data, held);
            rd_ready = tog ? (c % 2 == 0) : 1'b1;
            if (rd_ready) begin
               if (rd_q.size() == 0) chk("rd_q_size", rd_q.size(), 1);
               else chk("rd_data", rd_data, rd_q.pop_front());
               beats++;
               stall = 0;
            end else begin
               stall = 1;
               held  = rd_data;
            end
         end else begin
            rd_ready = 1'b0;
         end
         if (wr_ready) begin
            if (first < 0) first = c;
            if (beats < 8) begin
               wr_data = wbuf[beats];
               model[base + beats] = wbuf[beats];
            end
            beats++;
         end
         tick();
         c++;
      end
      exp_rsp = rsp_q.pop_front();
      chk("rsp_seen", done_c >= 0, 1);
      if (done_c >= 0) chk("rsp_error", rsp_error, exp_rsp);
      chk("beats", beats, exp_beats);
      if (exp_err) chk("reject_lat", done_c, 0);
      else if (!tog) chk("done_lat", done_c, INIT_LAT + exp_beats);
      if (exp_beats > 0) chk("first_beat_lat", first, INIT_LAT);
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      tick();
      chk("rsp_pulse_end", rsp_valid, 0);
      chk("busy_end", busy, 0);
   endtask

   task automatic watch_quiet(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         seen = seen | rsp_valid | rd_valid | wr_ready;
         tick();
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      int c;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
      tick(); tick();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_error", rsp_error, 0);
      rst = 1'b0;
      tick();

      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
      run_burst(1'b1, 64'd0, 16'd4, 1'b0, 1'b0);
      run_burst(1'b0, 64'd0, 16'd4, 1'b0, 1'b0);

      wbuf[0] = 8'h5A; wbuf[1] = 8'hA5; wbuf[2] = 8'hC3; wbuf[3] = 8'h3C;
      run_burst(1'b1, 64'd1020, 16'd4, 1'b0, 1'b0);
      run_burst(1'b0, 64'd1020, 16'd4, 1'b0, 1'b0);

      run_burst(1'b0, 64'd1021, 16'd4, 1'b0, 1'b1);
      run_burst(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 1'b0, 1'b1);
      run_burst(1'b1, 64'd0, 16'd257, 1'b0, 1'b1);
      run_burst(1'b0, 64'd0, 16'd3, 1'b1, 1'b0);
      run_burst(1'b0, 64'd5, 16'd0, 1'b0, 1'b0);

      // Reset while the latency counter is running.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd0; req_len = 16'd4;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      chk("wait_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wait_rst_busy", busy, 0);
      chk("wait_rst_req_ready", req_ready, 1);
      watch_quiet("wait_rst_quiet");

      // Reset after two of four write beats: first two bytes land, the rest keep old contents.
      wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
      run_burst(1'b1, 64'd100, 16'd4, 1'b0, 1'b0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd100; req_len = 16'd4;
      wr_valid = 1'b1; wr_data = 8'hA1;
      tick();
      req_valid = 1'b0;
      c = 0;
      while (!wr_ready && c < 50) begin
         tick();
         c++;
      end
      chk("xfer_wr_ready", wr_ready, 1);
      tick();
      wr_data = 8'hA2;
      tick();
      wr_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model[100] = 8'hA1;
      model[101] = 8'hA2;
      chk("xfer_rst_busy", busy, 0);
      watch_quiet("xfer_rst_quiet");
      run_burst(1'b0, 64'd100, 16'd4, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
